id_ex_pipe_reg: RTL and testbench

Parametrised ID->EX pipeline register for the 5-stage core. It is the next generation of the plain ID/EX latch and adds a valid/ready handshake on both sides. A 2-entry skid buffer lets the EX stage stall without a combinational ready path back into decode. A synchronous flush inserts a bubble on branch redirect. It carries PC, operand data, immediate, funct bits, rd, ALUOp and six control strobes.

---
 rtl/id_ex_pipe_reg.sv | 173 +++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with a valid/ready handshake on both sides.
// A two-entry skid buffer keeps in_ready free of any combinational path from out_ready.
module id_ex_pipe_reg #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int FUNCT_W = 4,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [FUNCT_W-1:0] in_funct,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [ALUOP_W-1:0] in_alu_op,
    input  logic [5:0]         in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_rs1_data,
    output logic [XLEN-1:0]    out_rs2_data,
    output logic [XLEN-1:0]    out_imm,
    output logic [FUNCT_W-1:0] out_funct,
    output logic [RADDR_W-1:0] out_rd,
    output logic [ALUOP_W-1:0] out_alu_op,
    output logic [5:0]         out_ctrl,
    output logic [1:0]         occ
);

    localparam int DATA_W = 4 * XLEN + FUNCT_W + RADDR_W;
    localparam int CTL_W  = ALUOP_W + 6;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_main_data;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTL_W-1:0]    r_main_ctl;
    logic [CTL_W-1:0]    r_skid_ctl;
    logic [DATA_W-1:0]   w_in_data;
    logic [CTL_W-1:0]    w_in_ctl;
    logic                w_main_valid;
    logic                w_accept;
    logic                w_issue;
    logic                w_ld_main_in;
    logic                w_ld_main_skid;
    logic                w_ld_skid_in;

    assign w_in_data    = {in_pc, in_rs1_data, in_rs2_data, in_imm, in_funct, in_rd};
    assign w_in_ctl     = {in_alu_op, in_ctrl};
    assign w_main_valid = (r_state == ST_ONE) || (r_state == ST_FULL);

    // Ready only looks at registered occupancy, flush and reset.
    assign in_ready = ((r_state == ST_EMPTY) || (r_state == ST_ONE)) && !flush && !reset;
    assign w_accept = in_valid && in_ready;
    assign w_issue  = w_main_valid && out_ready;

    // Next-state and entry-load selection.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid_in   = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt  = ST_ONE;
                        w_ld_main_in = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_issue) begin
                        w_state_nxt  = ST_ONE;
                        w_ld_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt  = ST_FULL;
                        w_ld_skid_in = 1'b1;
                    end else if (w_issue) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_issue) begin
                        w_state_nxt    = ST_ONE;
                        w_ld_main_skid = 1'b1;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main entry payload; the skid entry refills it so order stays FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_data <= {DATA_W{1'b0}};
        end else if (w_ld_main_in) begin
            r_main_data <= w_in_data;
        end else if (w_ld_main_skid) begin
            r_main_data <= r_skid_data;
        end
    end

    // Main entry control; flush scrubs it so a stale strobe can never leak.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_ctl <= {CTL_W{1'b0}};
        end else if (flush) begin
            r_main_ctl <= {CTL_W{1'b0}};
        end else if (w_ld_main_in) begin
            r_main_ctl <= w_in_ctl;
        end else if (w_ld_main_skid) begin
            r_main_ctl <= r_skid_ctl;
        end
    end

    // Skid entry payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_data <= {DATA_W{1'b0}};
        end else if (w_ld_skid_in) begin
            r_skid_data <= w_in_data;
        end
    end

    // Skid entry control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_ctl <= {CTL_W{1'b0}};
        end else if (flush) begin
            r_skid_ctl <= {CTL_W{1'b0}};
        end else if (w_ld_skid_in) begin
            r_skid_ctl <= w_in_ctl;
        end
    end

    assign out_valid = w_main_valid;
    assign {out_pc, out_rs1_data, out_rs2_data, out_imm, out_funct, out_rd} = r_main_data;
    assign out_ctrl   = w_main_valid ? r_main_ctl[5:0] : 6'b000000;
    assign out_alu_op = w_main_valid ? r_main_ctl[CTL_W-1:6] : {ALUOP_W{1'b0}};
    assign occ        = r_state;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a queue of expected entries is filled on
// accepted inputs and compared against the head outputs every cycle.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic [1:0]  alu_op;
        logic [5:0]  ctrl;
    } item_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [63:0] in_rs1_data;
    logic [63:0] in_rs2_data;
    logic [63:0] in_imm;
    logic [3:0]  in_funct;
    logic [4:0]  in_rd;
    logic [1:0]  in_alu_op;
    logic [5:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_rs1_data;
    logic [63:0] out_rs2_data;
    logic [63:0] out_imm;
    logic [3:0]  out_funct;
    logic [4:0]  out_rd;
    logic [1:0]  out_alu_op;
    logic [5:0]  out_ctrl;
    logic [1:0]  occ;

    logic        in_valid32;
    logic        in_ready32;
    logic [31:0] in_imm32;
    logic [4:0]  in_rd32;
    logic        out_valid32;
    logic [31:0] out_pc32;
    logic [31:0] out_rs1_32;
    logic [31:0] out_rs2_32;
    logic [31:0] out_imm32;
    logic [3:0]  out_funct32;
    logic [4:0]  out_rd32;
    logic [1:0]  out_alu_op32;
    logic [5:0]  out_ctrl32;
    logic [1:0]  occ32;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    id_ex_pipe_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_funct(in_funct), .in_rd(in_rd),
        .in_alu_op(in_alu_op), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .out_funct(out_funct), .out_rd(out_rd),
        .out_alu_op(out_alu_op), .out_ctrl(out_ctrl), .occ(occ)
    );

    id_ex_pipe_reg #(.XLEN(32), .RADDR_W(5), .FUNCT_W(4), .ALUOP_W(2)) dut32 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .in_pc(32'h0000_0100), .in_rs1_data(32'h0000_0000), .in_rs2_data(32'h0000_0000),
        .in_imm(in_imm32), .in_funct(4'h0), .in_rd(in_rd32),
        .in_alu_op(2'b00), .in_ctrl(6'b000001),
        .out_valid(out_valid32), .out_ready(1'b1),
        .out_pc(out_pc32), .out_rs1_data(out_rs1_32), .out_rs2_data(out_rs2_32),
        .out_imm(out_imm32), .out_funct(out_funct32), .out_rd(out_rd32),
        .out_alu_op(out_alu_op32), .out_ctrl(out_ctrl32), .occ(occ32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic [63:0] pc, input logic [5:0] ctrl,
                          input logic [1:0] aop);
        in_valid    = v;
        in_pc       = pc;
        in_rs1_data = {$urandom, $urandom};
        in_rs2_data = {$urandom, $urandom};
        in_imm      = {$urandom, $urandom};
        in_funct    = 4'($urandom);
        in_rd       = 5'($urandom);
        in_alu_op   = aop;
        in_ctrl     = ctrl;
    endtask

    // Called at posedge+1 with inputs driven; checks head, updates model, advances one cycle.
    task automatic step();
        item_t hd;
        item_t it;
        bit    exp_ready;
        bit    acc;
        bit    iss;
        #1;
        exp_ready = (sb.size() < 2) && !flush;
        acc       = in_valid && exp_ready;
        iss       = (sb.size() > 0) && out_ready;
        check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
        check_eq("out_valid", 64'(out_valid), 64'(sb.size() > 0));
        check_eq("occ", 64'(occ), 64'(sb.size()));
        if (sb.size() > 0) begin
            hd = sb[0];
            check_eq("out_pc", out_pc, hd.pc);
            check_eq("out_rs1", out_rs1_data, hd.rs1);
            check_eq("out_rs2", out_rs2_data, hd.rs2);
            check_eq("out_imm", out_imm, hd.imm);
            check_eq("out_funct", 64'(out_funct), 64'(hd.funct));
            check_eq("out_rd", 64'(out_rd), 64'(hd.rd));
            check_eq("out_alu_op", 64'(out_alu_op), 64'(hd.alu_op));
            check_eq("out_ctrl", 64'(out_ctrl), 64'(hd.ctrl));
        end else begin
            check_eq("bubble_ctrl", 64'(out_ctrl), 64'd0);
            check_eq("bubble_alu_op", 64'(out_alu_op), 64'd0);
        end
        if (iss) begin
            void'(sb.pop_front());
        end
        if (flush) begin
            sb.delete();
        end else if (acc) begin
            it = '{pc: in_pc, rs1: in_rs1_data, rs2: in_rs2_data, imm: in_imm,
                   funct: in_funct, rd: in_rd, alu_op: in_alu_op, ctrl: in_ctrl};
            sb.push_back(it);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        in_valid32 = 1'b0;
        in_imm32   = 32'h0000_0000;
        in_rd32    = 5'd0;
        set_in(1'b0, 64'h0, 6'b000000, 2'b00);
        #3;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_occ", 64'(occ), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check_eq("rst_out_pc", out_pc, 64'd0);
        #9;
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Streaming at full throughput.
        out_ready = 1'b1;
        set_in(1'b1, 64'h0, 6'b100001, 2'b10); step();
        set_in(1'b1, 64'h4, 6'b010101, 2'b01); step();
        set_in(1'b1, 64'h8, 6'b001011, 2'b00); step();
        set_in(1'b0, 64'h0, 6'b000000, 2'b00); step();
        step();

        // Backpressure: fill, reject a third push, then drain in order.
        out_ready = 1'b0;
        set_in(1'b1, 64'h10, 6'b000011, 2'b01); step();
        set_in(1'b1, 64'h14, 6'b000011, 2'b01); step();
        set_in(1'b1, 64'h18, 6'b000011, 2'b01); step();
        step();
        out_ready = 1'b1;
        set_in(1'b0, 64'h0, 6'b000000, 2'b00); step();
        set_in(1'b1, 64'h18, 6'b000011, 2'b01); step();
        set_in(1'b0, 64'h0, 6'b000000, 2'b00); step();
        step();

        // Flush while full, with a competing input that must be dropped.
        out_ready = 1'b0;
        set_in(1'b1, 64'h30, 6'b000011, 2'b10); step();
        set_in(1'b1, 64'h34, 6'b000011, 2'b10); step();
        flush = 1'b1;
        set_in(1'b1, 64'h20, 6'b000011, 2'b10); step();
        flush = 1'b0;
        set_in(1'b0, 64'h0, 6'b000000, 2'b00); step();
        step();

        // Bubble gating: stale main ctrl must not show once empty.
        out_ready = 1'b1;
        set_in(1'b1, 64'h40, 6'b111111, 2'b11); step();
        set_in(1'b0, 64'h0, 6'b000000, 2'b00); step();
        step();

        // Async reset in the middle of a stall.
        out_ready = 1'b0;
        set_in(1'b1, 64'h50, 6'b110011, 2'b01); step();
        set_in(1'b1, 64'h54, 6'b110011, 2'b01); step();
        set_in(1'b0, 64'h0, 6'b000000, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_occ", 64'(occ), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd0);
        check_eq("arst_out_ctrl", 64'(out_ctrl), 64'd0);
        check_eq("arst_out_alu_op", 64'(out_alu_op), 64'd0);
        check_eq("arst_out_pc", out_pc, 64'd0);
        sb.delete();
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_eq("arst_rel_occ", 64'(occ), 64'd0);
        check_eq("arst_rel_valid", 64'(out_valid), 64'd0);

        // Narrow instance: full-width immediate and top rd pass through.
        in_valid32 = 1'b1;
        in_imm32   = 32'hFFFF_FFFF;
        in_rd32    = 5'd31;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        check_eq("w32_out_valid", 64'(out_valid32), 64'd1);
        check_eq("w32_out_imm", 64'(out_imm32), 64'h0000_0000_FFFF_FFFF);
        check_eq("w32_out_rd", 64'(out_rd32), 64'd31);
        @(posedge clk);
        #1;

        // Random traffic with occasional flush.
        for (int i = 0; i < 80; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 9) == 0);
            set_in(1'($urandom_range(0, 1)), {$urandom, $urandom}, 6'($urandom), 2'($urandom));
            step();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 64'h0, 6'b000000, 2'b00);
        step();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
